// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch,
// load/store and debug; one transaction in flight, debug first.
module mem_port_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      req,
   input  logic [2:0]      we,
   input  logic [3*AW-1:0] addr,
   input  logic [3*DW-1:0] wdata,
   output logic [2:0]      gnt,
   output logic [2:0]      done,
   output logic [DW-1:0]   rdata,
   output logic            busy,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata
);

   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
      $error("mem_port_arbiter: MEM_LAT must be in 1..7");
   end

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [1:0] win;
   logic       win_we;
   logic       rr_last;

   logic          arb;
   logic [1:0]    pick;
   logic          pick_we;
   logic [AW-1:0] pick_addr;
   logic [DW-1:0] pick_wdata;

   assign arb  = (state == IDLE || state == DONE) && (req != 3'b000);
   assign busy = (state != IDLE);

   // Debug always wins; a fetch/load-store tie goes to the port not served last.
   always_comb begin
      pick = 2'd0;
      priority case (1'b1)
         req[2]:           pick = 2'd2;
         req[1] && req[0]: pick = rr_last ? 2'd0 : 2'd1;
         req[1]:           pick = 2'd1;
         default:          pick = 2'd0;
      endcase
   end

   always_comb begin
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      unique case (pick)
         2'd2: begin
            pick_we    = we[2];
            pick_addr  = addr[2*AW +: AW];
            pick_wdata = wdata[2*DW +: DW];
         end
         2'd1: begin
            pick_we    = we[1];
            pick_addr  = addr[1*AW +: AW];
            pick_wdata = wdata[1*DW +: DW];
         end
         default: begin
            pick_we    = we[0];
            pick_addr  = addr[0 +: AW];
            pick_wdata = wdata[0 +: DW];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         win       <= '0;
         win_we    <= 1'b0;
         rr_last   <= 1'b1;
         gnt       <= '0;
         done      <= '0;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         gnt    <= 3'b000;
         done   <= 3'b000;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (arb) begin
                  state     <= ACCESS;
                  win       <= pick;
                  win_we    <= pick_we;
                  mem_addr  <= pick_addr;
                  mem_wdata <= pick_wdata;
                  gnt       <= 3'b001 << pick;
                  mem_en    <= 1'b1;
                  mem_we    <= pick_we;
                  if (pick != 2'd2) rr_last <= pick[0];
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state <= WAIT;
               cnt   <= 3'd1;
            end
            WAIT: begin
               if (cnt == LAT) begin
                  state <= DONE;
                  done  <= 3'b001 << win;
                  if (!win_we) rdata <= mem_rdata;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: arbiters with MEM_LAT 1 and 4 checked against a
// transaction-timeline model plus directed literal expectations.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   logic [2:0]  req_a    [2];
   logic [2:0]  we_a     [2];
   logic [47:0] addr_a   [2];
   logic [95:0] wdata_a  [2];
   logic [2:0]  gnt_a    [2];
   logic [2:0]  done_a   [2];
   logic [31:0] rdata_a  [2];
   logic        busy_a   [2];
   logic        en_a     [2];
   logic        mwe_a    [2];
   logic [15:0] maddr_a  [2];
   logic [31:0] mwdata_a [2];

   int gq_port[$];
   int gq_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   for (genvar ln = 0; ln < 2; ln++) begin : g_lane
      localparam int L = (ln == 0) ? 1 : 4;

      logic [31:0] mrd;
      logic [31:0] mmem    [256];
      logic [31:0] pmem    [256];
      logic [31:0] hist    [8];
      logic [2:0]  e_gnt   [16];
      logic [2:0]  e_done  [16];
      logic        e_busy  [16];
      logic        e_en    [16];
      logic        e_we    [16];
      logic [15:0] e_addr  [16];
      logic [31:0] e_wdata [16];
      logic        e_upd   [16];
      logic [31:0] e_val   [16];
      logic [31:0] cur_rd;
      logic        rr_last;
      int          next_arb;
      bit          loaded = 1'b0;

      mem_port_arbiter #(.AW(16), .DW(32), .MEM_LAT(L)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req       (req_a[ln]),
         .we        (we_a[ln]),
         .addr      (addr_a[ln]),
         .wdata     (wdata_a[ln]),
         .gnt       (gnt_a[ln]),
         .done      (done_a[ln]),
         .rdata     (rdata_a[ln]),
         .busy      (busy_a[ln]),
         .mem_en    (en_a[ln]),
         .mem_we    (mwe_a[ln]),
         .mem_addr  (maddr_a[ln]),
         .mem_wdata (mwdata_a[ln]),
         .mem_rdata (mrd)
      );

      task automatic clr(input int i);
         e_gnt[i]   = '0;
         e_done[i]  = '0;
         e_busy[i]  = 1'b0;
         e_en[i]    = 1'b0;
         e_we[i]    = 1'b0;
         e_addr[i]  = '0;
         e_wdata[i] = '0;
         e_upd[i]   = 1'b0;
         e_val[i]   = '0;
      endtask

      always @(negedge clk) begin : model
         int         s, n, d;
         logic [1:0] w;
         logic [7:0] a;
         string      tag;
         if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
               mmem[i] = 32'hC0DE_0000 | 32'(i);
               pmem[i] = 32'hC0DE_0000 | 32'(i);
            end
            mmem[8'h10] = 32'hDEAD_BEEF;
            pmem[8'h10] = 32'hDEAD_BEEF;
            for (int i = 0; i < 8; i++) hist[i] = '0;
            for (int i = 0; i < 16; i++) clr(i);
            cur_rd   = '0;
            rr_last  = 1'b1;
            next_arb = 0;
            loaded   = 1'b1;
         end
         // memory macro: data for an access shows up L cycles later
         if (en_a[ln] && mwe_a[ln]) mmem[maddr_a[ln][7:0]] = mwdata_a[ln];
         if (en_a[ln] && !mwe_a[ln]) hist[cyc % 8] = mmem[maddr_a[ln][7:0]];
         else hist[cyc % 8] = 32'hBAD0_0000 | 32'(cyc & 16'hFFFF);
         mrd = hist[(cyc + 8 - L) % 8];

         s   = cyc % 16;
         tag = $sformatf("lane%0d cyc%0d", ln, cyc);
         if (reset) begin
            for (int i = 0; i < 16; i++) clr(i);
            cur_rd   = '0;
            rr_last  = 1'b1;
            next_arb = cyc + 1;
            chk({tag, " rst ctl"},
                {gnt_a[ln], done_a[ln], busy_a[ln], en_a[ln], mwe_a[ln]}, '0);
            chk({tag, " rst data"}, {maddr_a[ln], rdata_a[ln]}, '0);
            chk({tag, " rst wdata"}, mwdata_a[ln], '0);
         end else begin
            if (e_upd[s]) cur_rd = e_val[s];
            chk({tag, " gnt"}, gnt_a[ln], e_gnt[s]);
            chk({tag, " done"}, done_a[ln], e_done[s]);
            chk({tag, " busy"}, busy_a[ln], e_busy[s]);
            chk({tag, " mem_en"}, en_a[ln], e_en[s]);
            chk({tag, " mem_we"}, mwe_a[ln], e_we[s]);
            chk({tag, " rdata"}, rdata_a[ln], cur_rd);
            if (e_en[s]) begin
               chk({tag, " mem_addr"}, maddr_a[ln], e_addr[s]);
               chk({tag, " mem_wdata"}, mwdata_a[ln], e_wdata[s]);
            end
            clr(s);
            if (cyc >= next_arb && req_a[ln] != 3'b000) begin
               if (req_a[ln][2]) w = 2'd2;
               else if (req_a[ln][1:0] == 2'b11) w = {1'b0, ~rr_last};
               else if (req_a[ln][1]) w = 2'd1;
               else w = 2'd0;
               n = (cyc + 1) % 16;
               e_gnt[n]   = 3'b001 << w;
               e_en[n]    = 1'b1;
               e_we[n]    = we_a[ln][w];
               e_addr[n]  = addr_a[ln][w*16 +: 16];
               e_wdata[n] = wdata_a[ln][w*32 +: 32];
               for (int k = 1; k <= L + 2; k++) e_busy[(cyc + k) % 16] = 1'b1;
               d = (cyc + 2 + L) % 16;
               e_done[d] = 3'b001 << w;
               a = addr_a[ln][w*16 +: 8];
               if (we_a[ln][w]) begin
                  pmem[a] = wdata_a[ln][w*32 +: 32];
               end else begin
                  e_upd[d] = 1'b1;
                  e_val[d] = pmem[a];
               end
               if (w != 2'd2) rr_last = w[0];
               next_arb = cyc + 2 + L;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && gnt_a[0] != 3'b000) begin
         gq_port.push_back(gnt_a[0][2] ? 2 : (gnt_a[0][1] ? 1 : 0));
         gq_cyc.push_back(cyc);
      end
   end

   initial begin : stim
      int t, u, act;
      int exp2[4];
      int exp3[6];
      exp2 = '{0, 1, 0, 1};
      exp3 = '{2, 2, 2, 2, 0, 1};
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_a[i]   = '0;
         we_a[i]    = '0;
         addr_a[i]  = '0;
         wdata_a[i] = '0;
      end
      tick(3);
      chk("reset gnt", gnt_a[0], 3'b000);
      chk("reset busy", busy_a[0], 1'b0);
      chk("reset mem_en", en_a[0], 1'b0);
      chk("reset rdata", rdata_a[0], 32'h0);
      chk("reset mem_addr", maddr_a[0], 16'h0);
      reset = 1'b0;

      // single fetch read
      tick(1);
      addr_a[0][15:0] = 16'h0010;
      req_a[0] = 3'b001;
      tick(1);
      chk("t1 gnt", gnt_a[0], 3'b001);
      chk("t1 mem_en", en_a[0], 1'b1);
      chk("t1 mem_addr", maddr_a[0], 16'h0010);
      chk("t1 busy c1", busy_a[0], 1'b1);
      tick(1);
      req_a[0] = 3'b000;
      chk("t1 busy c2", busy_a[0], 1'b1);
      chk("t1 no early done", done_a[0], 3'b000);
      tick(1);
      chk("t1 done", done_a[0], 3'b001);
      chk("t1 rdata", rdata_a[0], 32'hDEAD_BEEF);
      chk("t1 busy c3", busy_a[0], 1'b1);
      tick(1);
      chk("t1 busy c4", busy_a[0], 1'b0);
      chk("t1 rdata held", rdata_a[0], 32'hDEAD_BEEF);

      // fetch and load/store contend from reset
      rst_pulse();
      gq_port.delete();
      gq_cyc.delete();
      t = cyc;
      addr_a[0][15:0]  = 16'h0020;
      addr_a[0][31:16] = 16'h0024;
      req_a[0] = 3'b011;
      tick(12);
      req_a[0] = 3'b000;
      tick(3);
      chk("t2 grants", gq_port.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2 port%0d", i), gq_port[i], exp2[i]);
         chk($sformatf("t2 cyc%0d", i), gq_cyc[i] - t, 1 + 3 * i);
      end

      // debug starves the others, then round-robin resumes
      gq_port.delete();
      gq_cyc.delete();
      addr_a[0][47:32] = 16'h0030;
      req_a[0] = 3'b101;
      tick(6);
      req_a[0] = 3'b111;
      tick(6);
      req_a[0] = 3'b011;
      tick(6);
      req_a[0] = 3'b000;
      tick(4);
      chk("t3 grants", gq_port.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3 port%0d", i), gq_port[i], exp3[i]);

      // load/store write then fetch read-back
      addr_a[0][31:16]  = 16'h0040;
      wdata_a[0][63:32] = 32'h1234_5678;
      we_a[0]  = 3'b010;
      req_a[0] = 3'b010;
      tick(1);
      chk("t4 gnt", gnt_a[0], 3'b010);
      chk("t4 mem_we", mwe_a[0], 1'b1);
      tick(1);
      req_a[0] = 3'b000;
      we_a[0]  = 3'b000;
      chk("t4 mem_we low", mwe_a[0], 1'b0);
      tick(1);
      chk("t4 done", done_a[0], 3'b010);
      chk("t4 rdata kept", rdata_a[0], 32'hC0DE_0024);
      tick(1);
      addr_a[0][15:0] = 16'h0040;
      req_a[0] = 3'b001;
      tick(2);
      req_a[0] = 3'b000;
      tick(1);
      chk("t4 rb done", done_a[0], 3'b001);
      chk("t4 rb rdata", rdata_a[0], 32'h1234_5678);
      tick(2);

      // idle stretch
      act = 0;
      repeat (20) begin
         tick(1);
         if (gnt_a[0] != 0 || done_a[0] != 0 || en_a[0] || busy_a[0]) act++;
      end
      chk("t6 idle activity", act, 0);

      // MEM_LAT=4: reset in second WAIT cycle of a write
      t = cyc;
      addr_a[1][31:16]  = 16'h0050;
      wdata_a[1][63:32] = 32'hA5A5_A5A5;
      we_a[1]  = 3'b010;
      req_a[1] = 3'b010;
      tick(2);
      req_a[1] = 3'b000;
      we_a[1]  = 3'b000;
      tick(1);
      reset = 1'b1;
      #1;
      chk("t5 rst ctl",
          {gnt_a[1], done_a[1], busy_a[1], en_a[1], mwe_a[1]}, '0);
      chk("t5 rst addr", maddr_a[1], 16'h0);
      chk("t5 rst wdata", mwdata_a[1], 32'h0);
      tick(1);
      reset = 1'b0;
      tick(1);
      u = cyc;
      addr_a[1][15:0] = 16'h0050;
      req_a[1] = 3'b001;
      tick(2);
      req_a[1] = 3'b000;
      tick(3);
      chk("t5 no early done", done_a[1], 3'b000);
      tick(1);
      chk("t5 done latency", cyc - u, 6);
      chk("t5 done", done_a[1], 3'b001);
      chk("t5 rdata", rdata_a[1], 32'hA5A5_A5A5);
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction memory between three requesters: the control unit's instruction fetch, its load/store path, and the debug/boot loader. One transaction is in flight at a time. Debug has strict priority, and fetch and load/store alternate round-robin. Each transaction sees a fixed, parameterized memory read latency. The arbiter sits between the control FSM's memory-facing signals and the memory macro, and exposes `busy` so the FSM can stall.

## Interface
- `AW`, 16, address width.
- `DW`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles: from the `mem_en` cycle to `mem_rdata` valid. Legal range 1..7; any other value is an elaboration error.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  3  request per port: bit0 fetch, bit1 load/store, bit2 debug.
- `we`  in  3  per-port write enable (1 = write, 0 = read).
- `addr`  in  3*AW  per-port address; port i uses bits `[i*AW +: AW]`.
- `wdata`  in  3*DW  per-port write data; port i uses bits `[i*DW +: DW]`.
- `gnt`  out  3  one-hot, 1-cycle pulse: the request is accepted.
- `done`  out  3  one-hot, 1-cycle pulse: the transaction completed.
- `rdata`  out  DW  read data, valid while `done` is high; held otherwise.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data.

## Operation
- States and transitions:
  - IDLE → ACCESS when any `req` bit is set.
  - ACCESS → WAIT, always.
  - WAIT → DONE after `MEM_LAT` cycles in WAIT.
  - DONE → ACCESS if any `req` bit is set; otherwise DONE → IDLE.
- Arbitration happens only in IDLE or DONE:
  - If `req[2]` is set, port 2 wins.
  - Otherwise, if only one of `req[1:0]` is set, that port wins.
  - If both are set, the port not equal to `rr_last` wins.
  - `rr_last` is a 1-bit register updated on each grant to port 0 or 1. It is unchanged by debug grants.
- On the edge leaving IDLE/DONE, the arbiter latches the winner index, `we`, `addr` and `wdata` into internal registers. `gnt[winner]` is high in the following (ACCESS) cycle.
- ACCESS cycle: `mem_en` = 1 and `mem_we` = latched `we`. `mem_addr` and `mem_wdata` come from the latched values. Outside ACCESS, `mem_en` = 0 and `mem_we` = 0.
- WAIT: a 3-bit counter runs from 1 to `MEM_LAT`. In the last WAIT cycle, `mem_rdata` is captured into `rdata`, for reads only.
- DONE: `done[winner]` = 1 for that cycle, for both reads and writes. After a write, `rdata` keeps its previous value.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
  - Drop `req` in the cycle after `gnt`, unless issuing a new request.
  - A `req` still high in DONE is treated as a new request.
- Debug can starve fetch and load/store indefinitely. This is intended, because the loader runs with the CPU halted.
- `gnt` and `done` never go to a port whose `req` was low at arbitration.

## Timing
- Reset values: state IDLE. `gnt`, `done`, `busy`, `mem_en` and `mem_we` are 0. `rdata`, `mem_addr` and `mem_wdata` are 0. `rr_last` = 1, so fetch wins the first tie.
- Request seen at cycle t (in IDLE):
  - `gnt` and `mem_en` at t+1.
  - `mem_rdata` sampled at t+1+`MEM_LAT`.
  - `done` and `rdata` at t+2+`MEM_LAT`.
- Back-to-back throughput: one transaction per `MEM_LAT`+2 cycles, because arbitration in DONE overlaps the next ACCESS setup.
- `busy` is high from t+1 through the DONE cycle. It is low in DONE+1 only if no new request was accepted.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronous).
  - The in-flight transaction is dropped and no `done` is issued.
  - A write that already had its ACCESS cycle is not undone.
- Input changes during ACCESS/WAIT/DONE do not affect the in-flight transaction.

## Test plan
- `MEM_LAT`=1. Fetch reads addr 0x0010 (memory returns 0xDEADBEEF) at cycle 0 → `gnt[0]` at cycle 1, `mem_en` at cycle 1, `done[0]` at cycle 3 with `rdata` = 0xDEADBEEF, `busy` high for cycles 1-3.
- Fetch and load/store both request continuously after reset → grants alternate 0,1,0,1, starting with fetch; one grant every 3 cycles.
- Debug and fetch request together, then load/store joins → debug is granted every slot while `req[2]` is held. After debug drops, port 0/1 round-robin resumes from the pre-debug `rr_last`.
- Load/store writes 0x12345678 to 0x0040 → `mem_we`=1 only in the ACCESS cycle, `done[1]` 2 cycles later, `rdata` unchanged. A following fetch read of 0x0040 returns 0x12345678.
- `MEM_LAT`=4. `reset` asserted during the second WAIT cycle → all outputs 0 within the same cycle, no `done`, state IDLE. The next request completes with `done` 6 cycles after its request cycle.
- No `req` for 20 cycles → `mem_en`, `gnt`, `done` and `busy` stay 0 throughout.
